// File: rtl/uart_pkg.sv
// Shared UART encodings, transmit FSM states and baud divisor helper.
// UART_TX_TWO_STOP_EN adds the second stop-bit state to tx_state_e.
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone    = 2'b00,
    ParOdd     = 2'b01,
    ParEven    = 2'b10,
    ParNoneAlt = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    B2400  = 2'b00,
    B4800  = 2'b01,
    B9600  = 2'b10,
    B19200 = 2'b11
  } baud_e;

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StStop2  = 3'd5
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;
`endif

  // Cycles per bit, rounded to nearest.
  function automatic logic [14:0] baud_div(input int unsigned clk_hz, input baud_e baud);
    int unsigned rate;
    case (baud)
      B2400:   rate = 2400;
      B4800:   rate = 4800;
      B9600:   rate = 9600;
      default: rate = 19200;
    endcase
    return 15'((clk_hz + rate / 2) / rate);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable 15-bit down-counter; tick is high while the count sits at zero.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [14:0] div,
  output logic        tick
);

  logic [14:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = div;
    end else if (count_q != 15'd0) begin
      count_d = count_q - 15'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 15'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == 15'd0);

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Define UART_TX_TWO_STOP_EN for a second stop bit before done_flag.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  localparam logic [14:0] Div2400M1  = baud_div(CLK_FREQ_HZ, B2400) - 15'd1;
  localparam logic [14:0] Div4800M1  = baud_div(CLK_FREQ_HZ, B4800) - 15'd1;
  localparam logic [14:0] Div9600M1  = baud_div(CLK_FREQ_HZ, B9600) - 15'd1;
  localparam logic [14:0] Div19200M1 = baud_div(CLK_FREQ_HZ, B19200) - 15'd1;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        par_bit_q, par_bit_d;
  logic        use_par_q, use_par_d;
  baud_e       baud_q, baud_d;
  logic        tx_q, tx_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  logic        load;
  logic        tick;
  baud_e       div_baud;
  logic [14:0] div_load;
  parity_e     par_in;

  assign par_in = parity_e'(parity_type);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    par_bit_d = par_bit_q;
    use_par_d = use_par_q;
    baud_d    = baud_q;
    done_d    = 1'b0;
    load      = 1'b0;
    div_baud  = baud_q;

    case (state_q)
      StIdle: begin
        if (send) begin
          shift_d   = data_in;
          baud_d    = baud_e'(baud_rate);
          div_baud  = baud_e'(baud_rate);
          use_par_d = (par_in == ParOdd) || (par_in == ParEven);
          par_bit_d = (par_in == ParOdd) ? ~^data_in : ^data_in;
          bit_idx_d = 3'd0;
          load      = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          load    = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          load      = 1'b1;
          // Index wrapping back to zero marks the eighth data bit done.
          if (bit_idx_d == 3'd0) begin
            state_d = use_par_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (tick) begin
          load    = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
`ifdef UART_TX_TWO_STOP_EN
          load    = 1'b1;
          state_d = StStop2;
`else
          done_d  = 1'b1;
          state_d = StIdle;
`endif
        end
      end
`ifdef UART_TX_TWO_STOP_EN
      StStop2: begin
        if (tick) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Line level follows the state being entered so every output is registered.
  always_comb begin
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
    active_d = (state_d != StIdle);
  end

  always_comb begin
    case (div_baud)
      B2400:   div_load = Div2400M1;
      B4800:   div_load = Div4800M1;
      B9600:   div_load = Div9600M1;
      default: div_load = Div19200M1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      par_bit_q <= 1'b0;
      use_par_q <= 1'b0;
      baud_q    <= B2400;
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      par_bit_q <= par_bit_d;
      use_par_q <= use_par_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  uart_baud_tick u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .div  (div_load),
    .tick (tick)
  );

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit at a reduced clock so frames stay short.
module tb_uart_tx_unit;
  import uart_pkg::*;

  // 240 kHz gives DIV = 100 / 50 / 25 / 13 for 2400 / 4800 / 9600 / 19200.
  localparam int unsigned ClkHz = 240_000;

  logic       clk;
  logic       rst;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  int n_checks;
  int n_fail;

  uart_tx_unit #(
    .CLK_FREQ_HZ (ClkHz)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the edge that accepts send (frame cycle 0).
  task automatic start_frame(input logic [7:0] d, input logic [1:0] par, input logic [1:0] baud);
    @(negedge clk);
    data_in     = d;
    parity_type = par;
    baud_rate   = baud;
    send        = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
  endtask

  // Checks first and last cycle of every bit, then the done cycle. inj >= 0 pulses a
  // conflicting send at that frame cycle.
  task automatic run_frame(input string tag, input logic [10:0] exp_bits, input int nbits,
                           input int d, input int inj);
    for (int c = 0; c < nbits * d; c++) begin
      if (c == inj) begin
        send        = 1'b1;
        data_in     = 8'hFF;
        parity_type = 2'b00;
        baud_rate   = 2'b11;
      end else if (c == inj + 1) begin
        send = 1'b0;
      end
      if ((c % d == 0) || (c % d == d - 1)) begin
        check_eq($sformatf("%s tx bit%0d cyc%0d", tag, c / d, c), 32'(data_tx),
                 32'(exp_bits[c / d]));
        check_eq($sformatf("%s active cyc%0d", tag, c), 32'(active_flag), 32'd1);
      end
      if (c == nbits * d - 1) begin
        check_eq($sformatf("%s done early", tag), 32'(done_flag), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    check_eq($sformatf("%s done pulse", tag), 32'(done_flag), 32'd1);
    check_eq($sformatf("%s active end", tag), 32'(active_flag), 32'd0);
    check_eq($sformatf("%s idle line", tag), 32'(data_tx), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    n_checks = 0;
    n_fail   = 0;

    check_eq("div 2400 @50M", 32'(baud_div(50_000_000, B2400)), 32'd20833);
    check_eq("div 4800 @50M", 32'(baud_div(50_000_000, B4800)), 32'd10417);
    check_eq("div 9600 @50M", 32'(baud_div(50_000_000, B9600)), 32'd5208);
    check_eq("div 19200 @50M", 32'(baud_div(50_000_000, B19200)), 32'd2604);

    // Reset held with send high: reset must win.
    rst         = 1'b1;
    send        = 1'b1;
    data_in     = 8'h35;
    parity_type = 2'b01;
    baud_rate   = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("rst tx %0d", i), 32'(data_tx), 32'd1);
      check_eq($sformatf("rst active %0d", i), 32'(active_flag), 32'd0);
      check_eq($sformatf("rst done %0d", i), 32'(done_flag), 32'd0);
    end
    @(negedge clk);
    rst  = 1'b0;
    send = 1'b0;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (data_tx !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0) bad++;
    end
    check_eq("post-reset quiet", 32'(bad), 32'd0);

    // 9600 odd parity 0x35, with an ignored send of 0xFF during data bit 1.
    start_frame(8'h35, 2'b01, 2'b10);
    run_frame("odd9600", 11'b11001101010, 11, 25, 60);
    @(posedge clk);
    #1;
    check_eq("odd9600 done 1 cycle", 32'(done_flag), 32'd0);

    // 19200 even parity 0x35, then 0x0F back-to-back from the done cycle.
    start_frame(8'h35, 2'b10, 2'b11);
    run_frame("even19200", 11'b10001101010, 11, 13, -1);
    data_in     = 8'h0F;
    parity_type = 2'b11;
    baud_rate   = 2'b11;
    send        = 1'b1;
    @(posedge clk);
    #1;
    send = 1'b0;
    check_eq("b2b done cleared", 32'(done_flag), 32'd0);
    run_frame("b2b 0x0F", 11'b01000011110, 10, 13, -1);
    @(posedge clk);
    #1;
    check_eq("b2b done 1 cycle", 32'(done_flag), 32'd0);

    // 2400 no parity 0xA5.
    start_frame(8'hA5, 2'b11, 2'b00);
    run_frame("none2400", 11'b01101001010, 10, 100, -1);

    // Reset during data bit 3 abandons the frame.
    start_frame(8'h35, 2'b01, 2'b10);
    repeat (110) @(posedge clk);
    #1;
    check_eq("midrst pre bit3", 32'(data_tx), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst tx high", 32'(data_tx), 32'd1);
    check_eq("midrst active", 32'(active_flag), 32'd0);
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (done_flag !== 1'b0 || data_tx !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    check_eq("midrst no done", 32'(bad), 32'd0);
    start_frame(8'h35, 2'b01, 2'b10);
    run_frame("after rst", 11'b11001101010, 11, 25, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
